// File: rtl/keypad_scanner.sv
// -----------------------------------------------------------------------------
// keypad_scanner
//
// Scans a 4x4 active-low matrix keypad. One column is driven low at a time
// for CNT_SCAN clocks. At the end of each column slot the (synchronised) row
// lines are folded into a 16-bit snapshot, bit (row*4 + col) set when that key
// reads pressed. A full scan is four column slots. A snapshot replaces the
// debounced matrix state only after DEBOUNCE_SCANS identical consecutive
// scans. A two-state FSM turns the debounced matrix into a single press event
// carrying the lowest pressed key code, plus a held-level flag.
//
// Optional feature (compile-time macro KEYPAD_REPEAT_EN):
//   While a key is held, key_valid pulses again every REPEAT_SCANS full scans
//   with the unchanged key_code. When the macro is undefined, no repeat
//   counter exists and REPEAT_SCANS is not a parameter of the module.
//
// Parameters:
//   CNT_SCAN        clocks per column slot (>= 4, so the synchroniser settles
//                   after a column switch before the row lines are sampled)
//   DEBOUNCE_SCANS  identical consecutive scans needed to accept a state (2..15)
//   REPEAT_SCANS    full scans between auto-repeat events (KEYPAD_REPEAT_EN)
//
// Ports:
//   clk        system clock
//   resetn     synchronous active-low reset
//   col[3:0]   column drive, active-low, exactly one bit low
//   row[3:0]   row sense, active-low, asynchronous to clk
//   key_valid  one-cycle press (or repeat) event
//   key_code   code of the last accepted key, row*4 + col
//   key_down   high while a debounced key is held
// -----------------------------------------------------------------------------
module keypad_scanner #(
  parameter logic [26:0] CNT_SCAN       = 27'd100_000,
  parameter int unsigned DEBOUNCE_SCANS = 4
`ifdef KEYPAD_REPEAT_EN
  ,
  parameter int unsigned REPEAT_SCANS   = 200
`endif
) (
  input  logic       clk,
  input  logic       resetn,
  output logic [3:0] col,
  input  logic [3:0] row,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_down
);

  localparam logic [26:0] CNT_LAST  = CNT_SCAN - 27'd1;
  // Saturation value of the match counter and the value it must already hold
  // for the current (equal) scan to complete the acceptance run.
  localparam logic [3:0]  MATCH_MAX = 4'(DEBOUNCE_SCANS - 1);
  localparam logic [3:0]  ACCEPT_AT = 4'(DEBOUNCE_SCANS - 2);

  typedef enum logic {
    IDLE = 1'b0,
    HELD = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Row synchroniser. Idle (released) level is all-ones.
  // ---------------------------------------------------------------------------
  logic [3:0] row_meta;
  logic [3:0] row_sync;

  // NOTE: reset is synchronous here, so it sits inside the clocked branch and
  // the sensitivity list carries only the clock edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      // NOTE: non-blocking assignments make every register read the value from
      // before this edge, which is what turns these two lines into a 2-stage
      // shift rather than a single wire.
      row_meta <= row;
      row_sync <= row_meta;
    end
  end

  // ---------------------------------------------------------------------------
  // Column slot timing
  // ---------------------------------------------------------------------------
  logic [26:0] cnt;
  logic [1:0]  idx;
  logic        col_last;
  logic        scan_end;

  assign col_last = (cnt == CNT_LAST);
  assign scan_end = col_last && (idx == 2'd3);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt <= '0;
      idx <= '0;
    end else if (col_last) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + 27'd1;
    end
  end

  assign col = ~(4'b0001 << idx);

  // ---------------------------------------------------------------------------
  // Snapshot assembly. snap_next is the snapshot with the current column's
  // nibble replaced by the live sample; at scan end it is the completed scan,
  // so the comparison below sees column 3 without waiting another cycle.
  // ---------------------------------------------------------------------------
  logic [15:0] snap;
  logic [15:0] snap_next;
  logic [15:0] prev_snap;
  logic [15:0] debounced;
  logic [3:0]  match_cnt;

  always_comb begin
    // NOTE: assigning a full default before the loop keeps every bit driven on
    // every path, so no latch is inferred.
    snap_next = snap;
    for (int r = 0; r < 4; r++) begin
      snap_next[4 * r + int'(idx)] = ~row_sync[r];
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      snap      <= '0;
      prev_snap <= '0;
      match_cnt <= '0;
      debounced <= '0;
    end else begin
      if (col_last) begin
        snap <= snap_next;
      end
      if (scan_end) begin
        prev_snap <= snap_next;
        if (snap_next == prev_snap) begin
          if (match_cnt != MATCH_MAX) begin
            match_cnt <= match_cnt + 4'd1;
          end
          // Counter reaches (or already sits at) its ceiling on this edge:
          // DEBOUNCE_SCANS identical scans in a row have now been seen.
          if (match_cnt >= ACCEPT_AT) begin
            debounced <= snap_next;
          end
        end else begin
          match_cnt <= '0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Lowest-set-bit encoder: with several keys down, the lowest code wins.
  // ---------------------------------------------------------------------------
  logic [3:0] low_code;

  always_comb begin
    low_code = '0;
    for (int i = 15; i >= 0; i--) begin
      if (debounced[i]) begin
        low_code = 4'(i);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Press FSM
  // ---------------------------------------------------------------------------
  state_t state;
  state_t state_next;
  logic   press;
  logic   rep_fire;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    press      = 1'b0;
    case (state)
      IDLE: begin
        if (|debounced) begin
          state_next = HELD;
          press      = 1'b1;
        end
      end
      HELD: begin
        // Rollover and partial releases are ignored; only an all-clear
        // matrix ends the hold.
        if (~|debounced) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef KEYPAD_REPEAT_EN
  // ---------------------------------------------------------------------------
  // Auto-repeat: counts completed scans while the hold continues. Cleared in
  // IDLE, which also covers the entry into HELD.
  // ---------------------------------------------------------------------------
  localparam logic [15:0] REP_LAST = 16'(REPEAT_SCANS - 1);

  logic [15:0] rep_cnt;

  assign rep_fire = (state == HELD) && (state_next == HELD) && scan_end &&
                    (rep_cnt == REP_LAST);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      rep_cnt <= '0;
    end else if ((state != HELD) || (state_next != HELD)) begin
      rep_cnt <= '0;
    end else if (scan_end) begin
      rep_cnt <= rep_fire ? 16'd0 : rep_cnt + 16'd1;
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Registered outputs: key_code and key_valid update on the same edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!resetn) begin
      key_valid <= 1'b0;
      key_code  <= '0;
    end else begin
      key_valid <= press | rep_fire;
      if (press) begin
        key_code <= low_code;
      end
    end
  end

  assign key_down = (state == HELD);

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Reads a 4x4 matrix keypad on the board I/O; it is the input-side counterpart of the LED output drivers.
- Drives one column low at a time, samples the row lines, and debounces whole-matrix snapshots over several scans.
- Emits a one-cycle event carrying a 4-bit key code per debounced press, plus a held-level flag for downstream control logic.

Parameters:
- CNT_SCAN, 27'd100_000, clk cycles spent on each column (1 ms at 100 MHz); must be >= 4.
- DEBOUNCE_SCANS, 4, consecutive identical full-matrix scans required to accept a new state; range 2..15.
- REPEAT_SCANS, 200, full scans between auto-repeat events; used only when the optional feature is compiled in.

Ports:
- clk  input  1  system clock.
- resetn  input  1  reset.
- col  output  4  column drive, active-low, one-hot-low.
- row  input  4  row sense, active-low, externally pulled up, asynchronous to clk.
- key_valid  output  1  one-cycle press event.
- key_code  output  4  code of last accepted key = row*4 + col.
- key_down  output  1  high while a debounced key is held.

Behaviour:
- Reset and clock: reset resetn, synchronous, active-low; clock clk.
- Reset values: col=4'b1110 (column 0), key_valid=0, key_code=0, key_down=0. Internal scan counter, column index, snapshots, match counter and FSM are all cleared.
- Synchronizer: row passes through a 2-FF synchronizer before any use.
- Scan counter: cnt runs 0..CNT_SCAN-1 and wraps.
  - On the cycle cnt==CNT_SCAN-1, the synchronized row is sampled into the snapshot nibble for the current column, then the column index advances: 0->1->2->3->0.
  - col = ~(1<<idx). One full scan = 4*CNT_SCAN cycles.
- Snapshot: 16 bits, bit (row*4+col) = 1 when that row reads low while that column is driven.
- End of scan: at cnt==CNT_SCAN-1 with idx==3, the completed snapshot is compared with the previous scan's snapshot.
  - Equal: match_cnt increments, saturating at DEBOUNCE_SCANS-1.
  - Different: match_cnt=0.
  - When the snapshot equals the previous one and match_cnt reaches DEBOUNCE_SCANS-1, debounced <= snapshot on that same edge.
  - Net effect: a state is accepted after DEBOUNCE_SCANS identical consecutive scans.
- FSM, states IDLE and HELD:
  - IDLE -> HELD when debounced != 0. On that transition, key_code latches the lowest set bit index of debounced, and key_valid=1 for exactly the following cycle; key_code and key_valid change on the same edge.
  - HELD -> IDLE when debounced == 0. No event is generated on release.
  - In HELD, changes to debounced (extra keys pressed or some keys released) are ignored as long as debounced stays nonzero.
  - key_down = (state==HELD).
  - key_code holds its value until the next press event.
- Multiple keys: the lowest code wins. No rollover events while already HELD.
- Partial scans: a press beginning mid-scan shows up in that scan only for the columns not yet sampled. That scan differs from the next one and so never counts toward acceptance.
- Reset mid-operation: every state returns to reset values immediately. A key still held after reset produces a fresh event after debouncing.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined: while HELD, a repeat counter counts full scans. After REPEAT_SCANS scans, key_valid pulses again with the unchanged key_code and the counter restarts. The counter clears on entering HELD and in IDLE.
- Undefined: exactly one key_valid pulse per press; no repeat counter is synthesized.

Test Plan:
All scenarios use CNT_SCAN=4, DEBOUNCE_SCANS=3, REPEAT_SCANS=8; one scan = 16 cycles.
- Reset then idle 40 cycles, row=4'hF -> col steps 1110,1101,1011,0111 every 4 cycles and returns to 1110 at cycle 16; key_valid, key_down and key_code stay 0.
- Hold row=4'b1101 only while col==1011 (row1, col2) from a scan boundary -> exactly one key_valid pulse, with key_code=6 and key_down=1, one cycle after the 3rd complete scan ends.
- Toggle row1/col2 press every 5 cycles for 60 cycles, then hold steadily -> no pulse during bouncing; a single pulse with code 6 follows 3 clean scans after bouncing stops.
- Press code 6 and code 3 (row0, col3) simultaneously -> one pulse, key_code=3. Then releasing code 3 while code 6 stays held -> no new pulse, key_down stays 1.
- Release all keys -> key_down falls 3 clean scans after release; no key_valid pulse; key_code stays 3.
- Assert resetn=0 for 2 cycles mid-hold with the key still pressed -> outputs clear and col=1110, then a new pulse appears after 3 scans. With KEYPAD_REPEAT_EN defined, repeat pulses follow every 128 cycles while the key stays held.
